// File: rtl/led_pattern_seq.sv
// Programmable LED/P1 pattern sequencer: host register port, step prescaler,
// and an IDLE/LOAD/RUN sequencer producing sweep, bounce, blink or static patterns.
module led_pattern_seq #(
    parameter int WIDTH   = 8,
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_addr,
    input  logic [15:0]      cfg_wdata,
    output logic [WIDTH-1:0] pattern,
    output logic [2:0]       leds,
    output logic             running,
    output logic             wrap,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [1:0]       MODE_STATIC = 2'd0;
    localparam logic [1:0]       MODE_SWEEP  = 2'd1;
    localparam logic [1:0]       MODE_BOUNCE = 2'd2;
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    state_t             r_state;
    logic               r_enable;
    logic [1:0]         r_mode;
    logic [DIV_W-1:0]   r_div;
    logic [WIDTH-1:0]   r_stat;
    logic [DIV_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_pattern;
    logic [2:0]         r_leds;
    logic               r_dir;
    logic               r_phase;
    logic               r_wrap;

    state_t             w_state_nxt;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_pattern_nxt;
    logic               w_dir_nxt;
    logic               w_phase_nxt;
    logic               w_wrap_nxt;

    // Config port: cfg_wr is a single-cycle strobe with no back-pressure; every
    // strobe is accepted and the addressed register holds the new value next cycle.
    logic                     w_wr_ctrl;
    logic                     w_wr_div;
    logic                     w_wr_stat;
    logic                     w_wr_cmd;
    logic [WIDTH+DIV_W+15:0]  w_wd_wide;
    logic [WIDTH-1:0]         w_stat_wd;
    logic [DIV_W-1:0]         w_div_wd;
    logic                     w_unused;
    logic [1:0]               w_mode_nxt;
    logic [WIDTH-1:0]         w_stat_nxt;
    logic                     w_load_req;
    logic                     w_cnt_clr;
    logic                     w_tick;

    assign w_wr_ctrl = cfg_wr && (cfg_addr == 2'd0);
    assign w_wr_div  = cfg_wr && (cfg_addr == 2'd1);
    assign w_wr_stat = cfg_wr && (cfg_addr == 2'd2);
    assign w_wr_cmd  = cfg_wr && (cfg_addr == 2'd3);

    assign w_wd_wide = {{(WIDTH + DIV_W){1'b0}}, cfg_wdata};
    assign w_stat_wd = w_wd_wide[WIDTH-1:0];
    assign w_div_wd  = w_wd_wide[DIV_W-1:0];
    assign w_unused  = ^w_wd_wide;

    // Bypassed values so a write in this cycle is seen by LOAD seeding and static tracking.
    assign w_mode_nxt = w_wr_ctrl ? cfg_wdata[2:1] : r_mode;
    assign w_stat_nxt = w_wr_stat ? w_stat_wd : r_stat;

    assign w_load_req = (w_wr_ctrl && cfg_wdata[0] && (cfg_wdata[2:1] != r_mode))
                      || (w_wr_cmd && cfg_wdata[0]);
    assign w_cnt_clr  = w_load_req || w_wr_div;
    assign w_tick     = (r_state == ST_RUN) && r_enable && !w_cnt_clr && (r_cnt == r_div);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= 1'b0;
            r_mode   <= MODE_SWEEP;
            r_div    <= DIV_W'(DIV_RST);
            r_stat   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= cfg_wdata[0];
                r_mode   <= cfg_wdata[2:1];
            end
            if (w_wr_div) begin
                r_div <= w_div_wd;
            end
            if (w_wr_stat) begin
                r_stat <= w_stat_wd;
            end
        end
    end

    // Candidate next patterns for the shifting modes; a zero result reloads seed 1.
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_swp_pat;
    logic             w_swp_wrap;
    logic [WIDTH-1:0] w_bnc_pat;
    logic             w_bnc_dir;
    logic             w_bnc_wrap;

    assign w_shl = r_pattern << 1;
    assign w_shr = r_pattern >> 1;

    always_comb begin
        w_swp_pat  = w_shl;
        w_swp_wrap = 1'b0;
        if (r_pattern[WIDTH-1]) begin
            w_swp_pat  = ONE;
            w_swp_wrap = 1'b1;
        end else if (w_shl == '0) begin
            w_swp_pat = ONE;
        end
    end

    always_comb begin
        w_bnc_pat  = w_shl;
        w_bnc_dir  = r_dir;
        w_bnc_wrap = 1'b0;
        if (!r_dir) begin
            w_bnc_pat = w_shl;
            w_bnc_dir = w_shl[WIDTH-1];
        end else begin
            w_bnc_pat  = w_shr;
            w_bnc_dir  = !w_shr[0];
            w_bnc_wrap = w_shr[0];
        end
        if (w_bnc_pat == '0) begin
            w_bnc_pat  = ONE;
            w_bnc_dir  = 1'b0;
            w_bnc_wrap = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_pattern_nxt = r_pattern;
        w_dir_nxt     = r_dir;
        w_phase_nxt   = r_phase;
        w_wrap_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pattern_nxt = '0;
                if (r_enable) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!r_enable) begin
                    w_state_nxt   = ST_IDLE;
                    w_pattern_nxt = '0;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_dir_nxt   = 1'b0;
                    w_phase_nxt = 1'b1;
                    if ((w_mode_nxt == MODE_STATIC) || (w_mode_nxt == 2'd3)) begin
                        w_pattern_nxt = w_stat_nxt;
                    end else begin
                        w_pattern_nxt = ONE;
                    end
                end
            end
            ST_RUN: begin
                if (!r_enable) begin
                    w_state_nxt   = ST_IDLE;
                    w_pattern_nxt = '0;
                end else if (w_load_req) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    if (!w_cnt_clr && (r_cnt != r_div)) begin
                        w_cnt_nxt = r_cnt + DIV_W'(1);
                    end
                    case (r_mode)
                        MODE_STATIC: begin
                            w_pattern_nxt = w_stat_nxt;
                        end
                        MODE_SWEEP: begin
                            if (w_tick) begin
                                w_pattern_nxt = w_swp_pat;
                                w_wrap_nxt    = w_swp_wrap;
                            end
                        end
                        MODE_BOUNCE: begin
                            if (w_tick) begin
                                w_pattern_nxt = w_bnc_pat;
                                w_dir_nxt     = w_bnc_dir;
                                w_wrap_nxt    = w_bnc_wrap;
                            end
                        end
                        default: begin
                            if (w_tick) begin
                                // Blink: on-phase shows STAT, off-phase is dark; wrap on re-entering on.
                                w_phase_nxt   = !r_phase;
                                w_pattern_nxt = r_phase ? '0 : w_stat_nxt;
                                w_wrap_nxt    = !r_phase;
                            end
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pattern_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pattern <= '0;
            r_leds    <= 3'b000;
            r_dir     <= 1'b0;
            r_phase   <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pattern <= w_pattern_nxt;
            r_leds    <= w_pattern_nxt[2:0];
            r_dir     <= w_dir_nxt;
            r_phase   <= w_phase_nxt;
            r_wrap    <= w_wrap_nxt;
        end
    end

    assign pattern   = r_pattern;
    assign leds      = r_leds;
    assign running   = (r_state == ST_RUN);
    assign wrap      = r_wrap;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: directed scenarios plus random config traffic,
// checked every cycle against a position-counting reference model.
module tb_led_pattern_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_wr;
    logic [1:0]   cfg_addr;
    logic [15:0]  cfg_wdata;
    logic [W-1:0] pattern;
    logic [2:0]   leds;
    logic         running;
    logic         wrap;
    logic [1:0]   dbg_state;

    led_pattern_seq #(.WIDTH(W), .DIV_W(16), .DIV_RST(65535)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .pattern   (pattern),
        .leds      (leds),
        .running   (running),
        .wrap      (wrap),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sequencer phase (0 idle, 1 load, 2 run), step position within the cycle.
    int           m_st;
    bit           m_en;
    int           m_mode;
    int           m_div;
    logic [W-1:0] m_stat;
    int           m_cnt;
    int           m_pos;
    logic [W-1:0] m_pat;
    bit           m_wrap;

    function automatic logic [W-1:0] onehot(input int i);
        logic [W-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_step(input bit r, input bit wr, input int addr, input logic [15:0] wd);
        bit           ctrl_wr;
        bit           load_req;
        bit           clr;
        bit           tick;
        int           mode_now;
        int           len;
        logic [W-1:0] stat_now;
        len = 2 * W - 2;
        m_wrap = 1'b0;
        if (r) begin
            m_st = 0; m_en = 1'b0; m_mode = 1; m_div = 65535; m_stat = '0;
            m_cnt = 0; m_pos = 0; m_pat = '0;
            return;
        end
        ctrl_wr  = wr && (addr == 0);
        mode_now = ctrl_wr ? int'(wd[2:1]) : m_mode;
        stat_now = (wr && addr == 2) ? wd[W-1:0] : m_stat;
        load_req = (ctrl_wr && wd[0] && (mode_now != m_mode)) || (wr && addr == 3 && wd[0]);
        clr      = load_req || (wr && addr == 1);
        case (m_st)
            0: begin
                m_pat = '0;
                m_cnt = 0;
                if (m_en) m_st = 1;
            end
            1: begin
                m_cnt = 0;
                if (!m_en) begin
                    m_st = 0;
                    m_pat = '0;
                end else begin
                    m_st  = 2;
                    m_pos = 0;
                    m_pat = (mode_now == 0 || mode_now == 3) ? stat_now : onehot(0);
                end
            end
            default: begin
                if (!m_en) begin
                    m_st = 0; m_pat = '0; m_cnt = 0;
                end else if (load_req) begin
                    m_st = 1; m_cnt = 0;
                end else begin
                    tick  = !clr && (m_cnt == m_div);
                    m_cnt = (clr || tick) ? 0 : m_cnt + 1;
                    if (m_mode == 0) begin
                        m_pat = stat_now;
                    end else if (tick) begin
                        if (m_mode == 1) begin
                            m_pos = (m_pos + 1) % W;
                            m_pat = onehot(m_pos);
                        end else if (m_mode == 2) begin
                            m_pos = (m_pos + 1) % len;
                            m_pat = onehot(m_pos < W ? m_pos : len - m_pos);
                        end else begin
                            m_pos = (m_pos + 1) % 2;
                            m_pat = (m_pos == 0) ? stat_now : '0;
                        end
                        m_wrap = (m_pos == 0);
                    end
                end
            end
        endcase
        if (ctrl_wr) begin
            m_en   = wd[0];
            m_mode = int'(wd[2:1]);
        end
        if (wr && addr == 1) m_div = int'(wd);
        if (wr && addr == 2) m_stat = wd[W-1:0];
    endtask

    task automatic cycle(input bit r, input bit wr, input int addr, input int wd);
        rst       = r;
        cfg_wr    = wr;
        cfg_addr  = addr[1:0];
        cfg_wdata = wd[15:0];
        @(posedge clk);
        model_step(r, wr, addr, wd[15:0]);
        #1;
        check_val("pattern", pattern, m_pat);
        check_val("leds", leds, m_pat[2:0]);
        check_val("running", running, (m_st == 2));
        check_val("wrap", wrap, m_wrap);
        rst    = 1'b0;
        cfg_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic wr_reg(input int addr, input int data);
        cycle(0, 1, addr, data);
    endtask

    initial begin
        int n80;
        int a;
        int d;
        bit r;
        bit w;

        // Reset, then sweep with a 4-clock step period
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check_val("reset_pattern", pattern, 0);
        check_val("reset_running", running, 0);
        wr_reg(1, 3);
        wr_reg(0, 3);
        idle(40);

        // Bounce at full speed: exactly one 0x80 per 14-step cycle
        wr_reg(1, 0);
        wr_reg(0, 5);
        idle(3);
        n80 = 0;
        for (int i = 0; i < 28; i++) begin
            idle(1);
            if (pattern == 8'h80) n80++;
        end
        check_val("bounce_80_count", n80, 2);

        // Blink A5 with a mid-run STAT rewrite
        wr_reg(2, 'hA5);
        wr_reg(1, 1);
        wr_reg(0, 7);
        idle(5);
        wr_reg(2, 'h3C);
        idle(8);

        // Mode change coincident with a tick suppresses the step
        wr_reg(1, 3);
        wr_reg(0, 3);
        for (int k = 0; k < 200; k++) begin
            if (m_st == 2 && m_pat == 8'h10 && m_cnt == m_div) break;
            idle(1);
        end
        check_val("reach_0x10", pattern, 8'h10);
        wr_reg(0, 5);
        check_val("no_step_on_load", pattern, 8'h10);
        idle(1);
        check_val("load_seed_bounce", pattern, 8'h01);
        idle(10);

        // Disable and re-enable
        wr_reg(0, 3);
        idle(6);
        wr_reg(0, 2);
        idle(1);
        check_val("disable_pattern", pattern, 0);
        check_val("disable_running", running, 0);
        wr_reg(0, 3);
        idle(2);
        check_val("reenable_seed", pattern, 8'h01);

        // Reset mid-bounce on the way down, then restart with enable low
        wr_reg(0, 5);
        for (int k = 0; k < 200; k++) begin
            if (m_st == 2 && m_pat == 8'h08 && m_pos >= W) break;
            idle(1);
        end
        check_val("reach_0x08_down", pattern, 8'h08);
        cycle(1, 0, 0, 0);
        check_val("rst_pattern", pattern, 0);
        check_val("rst_leds", leds, 0);
        wr_reg(3, 1);
        idle(3);
        check_val("restart_disabled", running, 0);
        wr_reg(0, 3);
        idle(20);
        check_val("div_reset_hold", pattern, 8'h01);

        // Random config traffic
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 999) == 0);
            w = ($urandom_range(0, 11) == 0);
            a = $urandom_range(0, 3);
            case (a)
                0: d = ($urandom_range(0, 3) << 1) | ($urandom_range(0, 9) != 0) | ($urandom_range(0, 3) << 3);
                1: d = $urandom_range(0, 4);
                2: d = $urandom_range(0, 255) | ($urandom_range(0, 255) << 8);
                default: d = $urandom_range(0, 1) | ($urandom_range(0, 7) << 1);
            endcase
            cycle(r, w, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
